// File: rtl/reg_file_sb.sv
// 32 x 32b architectural register file with per-register pending-write scoreboard.
// Optional write-through bypass of WB data/retire into reads: define REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned PEND_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  pend_overflow
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  typedef logic [PEND_WIDTH-1:0] pend_t;
  localparam pend_t PendMax = '1;
  localparam pend_t PendOne = pend_t'(1);

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  pend_t                 cnt_q  [NumRegs];
  pend_t                 cnt_d  [NumRegs];
  logic                  ovf_q, ovf_d;

  logic                  issue_vld, wb_vld;
  logic [NumRegs-1:0]    issue_hit, wb_hit, busy;

  // Register 0 is hardwired: neither issue nor WB to it is ever tracked.
  assign issue_vld = issue_en && !flush && (issue_addr != '0);
  assign wb_vld    = write_en && (write_addr != '0);

  assign issue_hit = issue_vld ? ({{(NumRegs-1){1'b0}}, 1'b1} << issue_addr) : '0;
  assign wb_hit    = wb_vld    ? ({{(NumRegs-1){1'b0}}, 1'b1} << write_addr) : '0;

  // Pending counters
  always_comb begin
    for (int unsigned r = 0; r < NumRegs; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else begin
        case ({issue_hit[r], wb_hit[r]})
          2'b10: if (cnt_q[r] != PendMax) cnt_d[r] = cnt_q[r] + PendOne;
          2'b01: if (cnt_q[r] != '0)      cnt_d[r] = cnt_q[r] - PendOne;
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (issue_vld && (cnt_q[issue_addr] == PendMax)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ovf_q <= ovf_d;
    end
  end

  // Storage; a flush does not cancel a same-cycle WB commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_vld) begin
      regs_q[write_addr] <= write_data;
    end
  end

  // Read ports
  always_comb begin
    read_data_1 = '0;
    if (read_en_1 && (read_addr_1 != '0)) begin
      read_data_1 = regs_q[read_addr_1];
`ifdef REGFILE_BYPASS_EN
      if (wb_vld && (write_addr == read_addr_1)) read_data_1 = write_data;
`endif
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (read_en_2 && (read_addr_2 != '0)) begin
      read_data_2 = regs_q[read_addr_2];
`ifdef REGFILE_BYPASS_EN
      if (wb_vld && (write_addr == read_addr_2)) read_data_2 = write_data;
`endif
    end
  end

  // Hazard detection
  always_comb begin
    for (int unsigned r = 0; r < NumRegs; r++) begin
      busy[r] = (cnt_q[r] != '0);
`ifdef REGFILE_BYPASS_EN
      // The last outstanding write retiring this cycle is forwarded, so no hazard.
      if (wb_hit[r] && (cnt_q[r] == PendOne)) busy[r] = 1'b0;
`endif
    end
  end

  assign stall_req = (read_en_1 && (read_addr_1 != '0) && busy[read_addr_1]) ||
                     (read_en_2 && (read_addr_2 != '0) && busy[read_addr_2]);

  assign pend_overflow = ovf_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// checked every cycle against an array/counter model of the register file.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk, rst_n;
  logic        read_en_1, read_en_2, issue_en, write_en, flush;
  logic [4:0]  read_addr_1, read_addr_2, issue_addr, write_addr;
  logic [31:0] write_data, read_data_1, read_data_2;
  logic        stall_req, pend_overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ovf;

  reg_file_sb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_en_1    (read_en_1),
    .read_addr_1  (read_addr_1),
    .read_data_1  (read_data_1),
    .read_en_2    (read_en_2),
    .read_addr_2  (read_addr_2),
    .read_data_2  (read_data_2),
    .issue_en     (issue_en),
    .issue_addr   (issue_addr),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .flush        (flush),
    .stall_req    (stall_req),
    .pend_overflow(pend_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what a read and the hazard check must return this cycle
  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
    if (!en || a == 0) return 32'h0;
    if (Bypass && write_en && write_addr == a) return write_data;
    return m_regs[a];
  endfunction

  function automatic bit is_busy(input logic [4:0] a);
    if (m_cnt[a] == 0) return 1'b0;
    if (Bypass && write_en && write_addr == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_stall();
    return (read_en_1 && read_addr_1 != 0 && is_busy(read_addr_1)) ||
           (read_en_2 && read_addr_2 != 0 && is_busy(read_addr_2));
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_ovf = 1'b0;
  end

  always @(negedge rst_n) begin
    for (int r = 0; r < 32; r++) begin
      m_regs[r] <= '0;
      m_cnt[r]  <= 0;
    end
    m_ovf <= 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] <= '0;
        m_cnt[r]  <= 0;
      end
      m_ovf <= 1'b0;
    end else begin
      if (write_en && write_addr != 0) m_regs[write_addr] <= write_data;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
      end else begin
        if (issue_en && issue_addr != 0 && m_cnt[issue_addr] == 3) m_ovf <= 1'b1;
        if (!(issue_en && write_en && issue_addr == write_addr && issue_addr != 0)) begin
          if (issue_en && issue_addr != 0 && m_cnt[issue_addr] < 3)
            m_cnt[issue_addr] <= m_cnt[issue_addr] + 1;
          if (write_en && write_addr != 0 && m_cnt[write_addr] > 0)
            m_cnt[write_addr] <= m_cnt[write_addr] - 1;
        end
      end
    end
  end

  // Compare process: outputs checked against the model mid-cycle, every cycle
  always @(negedge clk) begin
    check("rd1", read_data_1, exp_read(read_en_1, read_addr_1));
    check("rd2", read_data_2, exp_read(read_en_2, read_addr_2));
    check("stall", {31'b0, stall_req}, {31'b0, exp_stall()});
    check("ovf", {31'b0, pend_overflow}, {31'b0, m_ovf});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit ie, input int ia, input bit we, input int wa,
                       input logic [31:0] wd, input bit r1, input int a1,
                       input bit r2, input int a2, input bit fl);
    issue_en    = ie;
    issue_addr  = 5'(ia);
    write_en    = we;
    write_addr  = 5'(wa);
    write_data  = wd;
    read_en_1   = r1;
    read_addr_1 = 5'(a1);
    read_en_2   = r2;
    read_addr_2 = 5'(a2);
    flush       = fl;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    drive(0, 0, 0, 0, 32'h0, 1, 5, 1, 31, 0);
    #1;
    check("t1_rd1_r5", read_data_1, 32'h0);
    check("t1_rd2_r31", read_data_2, 32'h0);
    check("t1_stall", {31'b0, stall_req}, 32'h0);
    check("t1_ovf", {31'b0, pend_overflow}, 32'h0);

    // Write and read back; $0 stays zero
    step();
    drive(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 32'h0, 1, 3, 0, 0, 0);
    #1;
    check("t2_rd_r3", read_data_1, 32'hDEADBEEF);
    step();
    drive(0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0);
    #1;
    check("t2_rd_r0", read_data_1, 32'h0);

    // RAW hazard on r8 resolved by WB
    step();
    drive(1, 8, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 1, 8, 0);
    #1;
    check("t3_stall_pending", {31'b0, stall_req}, 32'h1);
    step();
    drive(0, 0, 1, 8, 32'h55, 0, 0, 1, 8, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t3_wb_stall", {31'b0, stall_req}, 32'h0);
    check("t3_wb_data", read_data_2, 32'h55);
`else
    check("t3_wb_stall", {31'b0, stall_req}, 32'h1);
    check("t3_wb_data", read_data_2, 32'h0);
`endif
    step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 1, 8, 0);
    #1;
    check("t3_after_stall", {31'b0, stall_req}, 32'h0);
    check("t3_after_data", read_data_2, 32'h55);

    // Saturation and sticky overflow, then flush
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1, 4, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    end
    step();
    drive(1, 4, 0, 0, 32'h0, 1, 4, 0, 0, 0);
    #1;
    check("t4_ovf_before", {31'b0, pend_overflow}, 32'h0);
    step();
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0, 0, 0);
    #1;
    check("t4_ovf_set", {31'b0, pend_overflow}, 32'h1);
    check("t4_stall_sat", {31'b0, stall_req}, 32'h1);
    step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0, 0, 0);
    #1;
    check("t4_flush_stall", {31'b0, stall_req}, 32'h0);
    check("t4_ovf_sticky", {31'b0, pend_overflow}, 32'h1);

    // Issue and WB to the same reg in one cycle leave the count unchanged
    step();
    drive(1, 9, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    drive(1, 9, 1, 9, 32'h99, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 1, 9, 0);
    #1;
    check("t5_stall_r9", {31'b0, stall_req}, 32'h1);
    check("t5_data_r9", read_data_2, 32'h99);

    // Randomized traffic, compared each cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      step();
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
            $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-operation
    step();
    drive(0, 0, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 1);
    step();
    drive(1, 10, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 32'h0, 1, 3, 1, 10, 0);
    #1;
    check("t5_pre_rst_rd", read_data_1, 32'hA5A5A5A5);
    check("t5_pre_rst_stall", {31'b0, stall_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rd", read_data_1, 32'h0);
    check("t5_rst_stall", {31'b0, stall_req}, 32'h0);
    check("t5_rst_ovf", {31'b0, pend_overflow}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
